dm_4k: RTL and testbench

//  4 KiB word-addressed data memory (1024 x 32) for the single-cycle MIPS CPU datapath.

---
 rtl/dm_4k.sv | 39 +++
 tb/tb_dm_4k.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dm_4k.sv
// 4 KiB word-addressed data memory (1024 x 32) for the single-cycle MIPS datapath.
// Combinational read, synchronous full-word write, asynchronous active-low clear.
module dm_4k #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = din;
        end
    end

    // Reset wins over any write pending for the same edge, so it is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // No bypass: a same-address write becomes visible only after the edge.
    assign dout = mem_q[addr];

endmodule

// File: tb/tb_dm_4k.sv
// Self-checking bench for dm_4k: directed corner cases followed by randomized traffic
// compared against a plain array model of the memory.
module tb_dm_4k;

    logic        clk;
    logic        reset;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;

    logic [31:0] model [1024];
    int compared;
    int mismatched;

    dm_4k dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .din   (din),
        .we    (we),
        .dout  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 1024; i++) begin
            model[i] = 32'h0;
        end
    endtask

    // Sets up the inputs just after a falling edge, half a cycle before the next write edge.
    task automatic applyStimulus(input logic [9:0] a, input logic [31:0] d, input logic w);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = w;
    endtask

    // A write is committed by the edge only when reset is high and we is set.
    task automatic clockEdge();
        if (reset && we) begin
            model[addr] = din;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [9:0] a);
        we   = 1'b0;
        addr = a;
        #1;
        checkOutput(tag, dout, model[a]);
    endtask

    task automatic writeWord(input logic [9:0] a, input logic [31:0] d);
        applyStimulus(a, d, 1'b1);
        clockEdge();
        we = 1'b0;
    endtask

    initial begin
        logic [9:0]  ra;
        logic [31:0] rd;
        logic        rw;

        compared   = 0;
        mismatched = 0;
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        clearModel();

        #2 reset = 1'b0;

        // Writes attempted while reset is held low must never land.
        addr = 10'd1;
        din  = 32'hCAFEF00D;
        we   = 1'b1;
        repeat (3) clockEdge();
        readCheck("rst_hold_a0", 10'd0);
        readCheck("rst_hold_a1", 10'd1);
        readCheck("rst_hold_a1023", 10'd1023);

        applyStimulus(10'd1, 32'h0000000F, 1'b1);
        reset = 1'b1;
        clockEdge();
        checkOutput("first_write_a1", dout, 32'h0000000F);

        applyStimulus(10'd1, 32'hDEADBEEF, 1'b0);
        repeat (3) clockEdge();
        checkOutput("we0_hold_a1", dout, 32'h0000000F);

        writeWord(10'd0, 32'hAAAA5555);
        writeWord(10'd1023, 32'h12345678);
        readCheck("rd_a0", 10'd0);
        checkOutput("rd_a0_const", dout, 32'hAAAA5555);
        readCheck("rd_a1023", 10'd1023);
        checkOutput("rd_a1023_const", dout, 32'h12345678);
        readCheck("rd_a1_still", 10'd1);
        checkOutput("rd_a1_const", dout, 32'h0000000F);

        applyStimulus(10'd2, 32'h11111111, 1'b1);
        #1;
        checkOutput("rdw_before", dout, 32'h00000000);
        clockEdge();
        checkOutput("rdw_after", dout, 32'h11111111);

        // Reset mid-cycle with a write pending: everything is lost, the write is dropped.
        applyStimulus(10'd5, 32'h5A5A5A5A, 1'b1);
        #2 reset = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_now_a5", dout, 32'h0);
        readCheck("rst_now_a0", 10'd0);
        readCheck("rst_now_a1", 10'd1);
        readCheck("rst_now_a2", 10'd2);
        readCheck("rst_now_a1023", 10'd1023);
        addr = 10'd5;
        we   = 1'b1;
        clockEdge();
        @(negedge clk);
        reset = 1'b1;
        readCheck("post_rst_a5", 10'd5);
        readCheck("post_rst_a0", 10'd0);
        readCheck("post_rst_a1", 10'd1);
        readCheck("post_rst_a2", 10'd2);
        readCheck("post_rst_a1023", 10'd1023);

        // Random traffic, biased toward a few addresses so overwrites and rereads happen.
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023;
            end
            rd = $urandom;
            rw = ($urandom_range(0, 2) != 0);
            applyStimulus(ra, rd, rw);
            #1;
            checkOutput("rnd_pre_edge", dout, model[ra]);
            clockEdge();
            checkOutput("rnd_post_edge", dout, model[ra]);
            readCheck("rnd_read", 10'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                clearModel();
                #1;
                readCheck("rnd_rst_read", 10'($urandom_range(0, 7)));
                reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
